// File: rtl/line_prefetcher.sv
// Framebuffer line prefetcher: fills a double-buffered line RAM one row ahead
// and streams the front bank out on pixel strobes. `LINE_PREFETCH_STATS_EN adds underrun_count.
module line_prefetcher #(
  parameter int unsigned PIXEL_W  = 16,
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned H_PIXELS = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               newframe,
  input  logic               newline,
  input  logic               newpixel,
  input  logic               visible_line,
  input  logic               visible_window,
  input  logic [8:0]         v_active,
  input  logic [ADDR_W-1:0]  fb_base,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [PIXEL_W-1:0] mem_rdata,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
`ifdef LINE_PREFETCH_STATS_EN
  output logic [15:0]        underrun_count,
`endif
  output logic               underrun,
  output logic               underrun_sticky
);

  localparam int unsigned CW = $clog2(H_PIXELS);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       fcol, fcol_n;
  logic [8:0]          row, row_n;
  logic [ADDR_W-1:0]   base_q, base_n, addr_n;
  logic                bank_sel, bank_n;
  logic                abort_q, abort_n, restart_q, restart_n;
  logic [CW:0]         dcol, dcol_eff, dcol_n;
  logic                swap, trigger, start_fetch, busy, fill_we, load_addr, pix_hit;
  logic [PIXEL_W-1:0]  lram [2*H_PIXELS];

  assign mem_req = (state == REQ);

  always_comb begin
    swap        = newline && visible_line && !newframe;
    trigger     = newframe || swap;
    start_fetch = newframe || (swap && (({1'b0, row} + 10'd1) < {1'b0, v_active}));
    busy        = (state != IDLE);
    base_n      = newframe ? fb_base : base_q;
    row_n       = newframe ? '0 : ((swap && start_fetch) ? row + 9'd1 : row);
    bank_n      = swap ? ~bank_sel : bank_sel;

    state_n   = state;
    fcol_n    = fcol;
    abort_n   = abort_q;
    restart_n = restart_q;
    fill_we   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_fetch) begin
          state_n = REQ;
          fcol_n  = '0;
        end
      end
      REQ: begin
        // An outstanding request is held until acked; its data is then dropped
        // and the pending restart (if any) goes straight back to REQ at column 0.
        if (trigger) begin
          if (mem_ack) begin
            state_n = start_fetch ? REQ : IDLE;
            fcol_n  = '0;
            abort_n = 1'b0;
          end else begin
            abort_n   = 1'b1;
            restart_n = start_fetch;
          end
        end else if (mem_ack) begin
          if (abort_q) begin
            state_n = restart_q ? REQ : IDLE;
            fcol_n  = '0;
            abort_n = 1'b0;
          end else begin
            fill_we = 1'b1;
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (trigger) begin
          state_n = start_fetch ? REQ : IDLE;
          fcol_n  = '0;
        end else if (fcol == CW'(H_PIXELS - 1)) begin
          state_n = IDLE;
        end else begin
          state_n = REQ;
          fcol_n  = fcol + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // The address register only loads on entry to a new request so it stays stable while mem_req is high.
    addr_n    = base_n + (ADDR_W'(row_n) << CW) + ADDR_W'(fcol_n);
    load_addr = (state_n == REQ) && ((state != REQ) || mem_ack);

    dcol_eff = newline ? '0 : dcol;
    pix_hit  = newpixel && visible_window && (dcol_eff < (CW+1)'(H_PIXELS));
    dcol_n   = dcol_eff;
    if (newpixel && visible_window && (dcol_eff != (CW+1)'(H_PIXELS)))
      dcol_n = dcol_eff + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n && fill_we)
      lram[{~bank_sel, fcol}] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      fcol            <= '0;
      row             <= '0;
      base_q          <= '0;
      bank_sel        <= 1'b0;
      abort_q         <= 1'b0;
      restart_q       <= 1'b0;
      dcol            <= '0;
      mem_addr        <= '0;
      pixel_data      <= '0;
      pixel_valid     <= 1'b0;
      underrun        <= 1'b0;
      underrun_sticky <= 1'b0;
`ifdef LINE_PREFETCH_STATS_EN
      underrun_count  <= '0;
`endif
    end else begin
      state     <= state_n;
      fcol      <= fcol_n;
      row       <= row_n;
      base_q    <= base_n;
      bank_sel  <= bank_n;
      abort_q   <= abort_n;
      restart_q <= restart_n;
      dcol      <= dcol_n;
      if (load_addr)
        mem_addr <= addr_n;
      underrun <= trigger && busy;
      if (trigger && busy)
        underrun_sticky <= 1'b1;
      else if (newframe)
        underrun_sticky <= 1'b0;
`ifdef LINE_PREFETCH_STATS_EN
      if (trigger && busy && (underrun_count != '1))
        underrun_count <= underrun_count + 16'd1;
`endif
      if (newpixel) begin
        pixel_valid <= pix_hit;
        pixel_data  <= pix_hit ? lram[{bank_n, dcol_eff[CW-1:0]}] : '0;
      end else if (newline) begin
        pixel_valid <= 1'b0;
        pixel_data  <= '0;
      end
    end
  end

endmodule
